// File: rtl/tt_factory_test_gen.sv
// tt_factory_test_gen: bring-up pattern source for a TT tile (loopback, counter, LFSR, walking-one)
// Config is latched from ui_in once after reset release; outputs pass ui_in through while in reset.
module tt_factory_test_gen #(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 8,
   parameter int               PRESC_W   = 4,
   parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] ui_in,
   output logic [WIDTH-1:0] uo_out,
   input  logic [WIDTH-1:0] uio_in,
   output logic [WIDTH-1:0] uio_out,
   output logic [WIDTH-1:0] uio_oe
);
   typedef enum logic {IDLE, RUN} state_e;
   state_e             state_q, state_d;
   logic [1:0]         sync_q, mode_q, mode_d;
   logic [PRESC_W-1:0] presc_q, presc_d, pc_q, pc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_n, walk_q, walk_d;
   logic               tick, frz, unused_ok;
   assign unused_ok = &{1'b0, ena};
   assign frz = ui_in[3];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         state_q <= IDLE;
         mode_q  <= '0;
         presc_q <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         lfsr_q  <= WIDTH'(1);
         walk_q  <= WIDTH'(1);
      end else begin
         sync_q  <= {sync_q[0], 1'b1};
         state_q <= state_d;
         mode_q  <= mode_d;
         presc_q <= presc_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         walk_q  <= walk_d;
      end
   end
   // A zero result would lock the LFSR, so it is forced back to the seed.
   always_comb begin
      lfsr_n = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
      if (lfsr_n == '0) lfsr_n = WIDTH'(1);
   end
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      presc_d = presc_q;
      tick    = state_q == RUN && !frz && pc_q == presc_q;
      pc_d    = (state_q != RUN || frz) ? pc_q : (tick ? '0 : pc_q + PRESC_W'(1));
      cnt_d   = (tick && mode_q == 2'd1) ? cnt_q + CNT_W'(1) : cnt_q;
      lfsr_d  = (tick && mode_q == 2'd2) ? lfsr_n : lfsr_q;
      walk_d  = (tick && mode_q == 2'd3) ? {walk_q[WIDTH-2:0], walk_q[WIDTH-1]} : walk_q;
      if (state_q == IDLE && sync_q[1]) begin
         state_d = RUN;
         mode_d  = ui_in[1:0];
         presc_d = ui_in[4 +: PRESC_W];
      end
   end
   always_comb begin
      uo_out  = '0;
      uio_out = '0;
      uio_oe  = '0;
      if (!rst_n) uo_out = ui_in;
      else if (state_q == RUN) begin
         case (mode_q)
            2'd0: uo_out = uio_in;
            2'd1: begin
               uo_out  = cnt_q[WIDTH-1:0];
               uio_out = cnt_q[CNT_W-1 -: WIDTH];
               uio_oe  = '1;
            end
            2'd2: begin
               uo_out  = lfsr_q;
               uio_out = lfsr_q;
               uio_oe  = '1;
            end
            default: begin
               uo_out  = walk_q;
               uio_out = ~walk_q;
               uio_oe  = '1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tt_factory_test_gen.sv
// tb_tt_factory_test_gen: directed stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_tt_factory_test_gen;
   typedef struct {
      string      nm;
      logic [7:0] uo;
      logic [7:0] uio;
      logic [7:0] oe;
   } exp_t;
   exp_t       q[$];
   logic       clk = 1'b1, rst_n = 1'b0, ena = 1'b1;
   logic [7:0] ui_in = '0, uio_in = '0;
   logic [7:0] uo_out, uio_out, uio_oe;
   int         n_chk = 0, n_fail = 0;
   int         pc, cnt, presc;
   logic [7:0] lf, wk, ev;
   logic [7:0] lfsr_tab [5] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};

   tt_factory_test_gen dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_o(input string nm, input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
      exp_t e;
      e.nm = nm;
      e.uo = uo;
      e.uio = uio;
      e.oe = oe;
      q.push_back(e);
   endtask

   task automatic do_reset(input logic [7:0] cfg);
      cyc();
      rst_n = 1'b0;
      ui_in = cfg;
      expect_o("rst_passthrough", cfg, 8'h00, 8'h00);
      cyc();
      rst_n = 1'b1;
      expect_o("idle_after_release", 8'h00, 8'h00, 8'h00);
      cyc();
      cyc();
      expect_o("idle_at_p1", 8'h00, 8'h00, 8'h00);
      cyc();
      pc = 0;
      cnt = 0;
   endtask

   task automatic run_cnt(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         if (!ui_in[3]) begin
            if (pc == presc) begin
               pc = 0;
               cnt = (cnt + 1) % 256;
            end else pc++;
         end
         expect_o(nm, 8'(cnt), 8'(cnt), 8'hFF);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if ({uo_out, uio_out, uio_oe} !== {e.uo, e.uio, e.oe}) begin
               n_fail++;
               $display("FAIL %s: got uo=%h uio=%h oe=%h, want uo=%h uio=%h oe=%h",
                        e.nm, uo_out, uio_out, uio_oe, e.uo, e.uio, e.oe);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: stimulus did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      ui_in = 8'hA5;
      uio_in = 8'h3C;
      #1;
      expect_o("async_reset_no_clock", 8'hA5, 8'h00, 8'h00);
      // counter, prescale 0, wrap
      do_reset(8'h01);
      presc = 0;
      expect_o("cnt_at_p2", 8'h00, 8'h00, 8'hFF);
      run_cnt("cnt_presc0", 257);
      // counter, prescale 3, freeze and ignored config changes
      do_reset(8'h31);
      presc = 3;
      expect_o("cnt3_at_p2", 8'h00, 8'h00, 8'hFF);
      run_cnt("cnt_presc3", 13);
      ui_in = 8'h39;
      run_cnt("cnt_frozen", 10);
      ui_in = 8'h72;
      run_cnt("cnt_cfg_ignored", 12);
      // LFSR
      do_reset(8'h02);
      lf = 8'h01;
      expect_o("lfsr_seed", 8'h01, 8'h01, 8'hFF);
      for (int i = 1; i <= 255; i++) begin
         cyc();
         lf = lf[0] ? ((lf >> 1) ^ 8'hB8) : (lf >> 1);
         if (lf == 8'h00) lf = 8'h01;
         ev = (i <= 5) ? lfsr_tab[i-1] : ((i == 255) ? 8'h01 : lf);
         expect_o(i == 255 ? "lfsr_period" : "lfsr_step", ev, ev, 8'hFF);
      end
      // walking one
      do_reset(8'h03);
      wk = 8'h01;
      expect_o("walk_seed", 8'h01, 8'hFE, 8'hFF);
      for (int i = 1; i <= 9; i++) begin
         cyc();
         wk = {wk[6:0], wk[7]};
         expect_o("walk_step", wk, ~wk, 8'hFF);
      end
      // loopback
      uio_in = 8'h3C;
      do_reset(8'h00);
      expect_o("loopback_3c", 8'h3C, 8'h00, 8'h00);
      cyc();
      uio_in = 8'h5A;
      expect_o("loopback_5a", 8'h5A, 8'h00, 8'h00);
      // reset pulse mid counter run
      do_reset(8'h01);
      presc = 0;
      expect_o("cnt_pre_pulse", 8'h00, 8'h00, 8'hFF);
      run_cnt("cnt_pre_pulse", 5);
      do_reset(8'h01);
      expect_o("cnt_restart_p2", 8'h00, 8'h00, 8'hFF);
      run_cnt("cnt_restart", 3);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
